// File: rtl/dsp_config_serializer_pkg.sv
// Shared types and sizing helpers for the DSP tile configuration serializer.
package dsp_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FIN
  } cfg_state_t;

  // Frozen length of the tile's configuration chain and the loader word width.
  localparam int DEF_CFG_LEN = 40;
  localparam int DEF_WORD_W  = 16;

  // Number of parallel words needed to carry one full frame.
  function automatic int calc_num_words(input int cfg_len, input int word_w);
    return (cfg_len + word_w - 1) / word_w;
  endfunction

  // Number of meaningful bits in the final (possibly partial) word.
  function automatic int calc_last_bits(input int cfg_len, input int word_w);
    return cfg_len - word_w * (calc_num_words(cfg_len, word_w) - 1);
  endfunction

endpackage

// File: rtl/dsp_config_serializer_if.sv
// Producer-side word handshake into the configuration serializer.
interface dsp_config_serializer_if
  import dsp_cfg_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W
);

  logic              cfg_start;
  logic [WORD_W-1:0] cfg_word;
  logic              cfg_valid;
  logic              cfg_ready;

  modport master (
    output cfg_start,
    output cfg_word,
    output cfg_valid,
    input  cfg_ready
  );

  modport slave (
    input  cfg_start,
    input  cfg_word,
    input  cfg_valid,
    output cfg_ready
  );

endinterface

// File: rtl/dsp_config_serializer_cfg_word_buffer.sv
// Hold register plus shift register: a word waits in hold while the previous
// one is shifted out, so the serial stream continues without a bubble.
module cfg_word_buffer
  import dsp_cfg_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [WORD_W-1:0]            wr_word,
  input  logic [$clog2(WORD_W+1)-1:0]  wr_bits,
  input  logic                         shift_en,
  output logic                         hold_valid,
  output logic                         sr_valid,
  output logic                         sr_bit
);

  localparam int REM_W = $clog2(WORD_W + 1);

  logic [WORD_W-1:0] hold_word;
  logic [REM_W-1:0]  hold_bits;
  logic [WORD_W-1:0] sr_word;
  logic [REM_W-1:0]  sr_rem;
  logic              shifting;
  logic              load;

  assign sr_valid = (sr_rem != '0);
  assign sr_bit   = sr_word[0];
  assign shifting = shift_en && sr_valid;
  // Refill when empty, or when the last bit leaves this cycle.
  assign load     = hold_valid && ((sr_rem == '0) || (shifting && (sr_rem == REM_W'(1))));

  // Occupancy flags and remaining-bit count.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid <= 1'b0;
      sr_rem     <= '0;
    end else begin
      if (wr_en) begin
        hold_valid <= 1'b1;
      end else if (load) begin
        hold_valid <= 1'b0;
      end
      if (load) begin
        sr_rem <= hold_bits;
      end else if (shifting) begin
        sr_rem <= sr_rem - 1'b1;
      end
    end
  end

  // Word storage and LSB-first shifting; qualified by the flags above.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      hold_word <= wr_word;
      hold_bits <= wr_bits;
    end
    if (load) begin
      sr_word <= hold_word;
    end else if (shifting) begin
      sr_word <= sr_word >> 1;
    end
  end

endmodule

// File: rtl/dsp_config_serializer.sv
// Loads a configuration frame as parallel words and streams it LSB-first onto
// the tile's configuration_input / configuration_enable pins.
module dsp_config_serializer
  import dsp_cfg_pkg::*;
#(
  parameter int CFG_LEN = DEF_CFG_LEN,
  parameter int WORD_W  = DEF_WORD_W
) (
  input  logic                    clk,
  input  logic                    RST,
  dsp_config_serializer_if.slave  cfg,
  output logic                    configuration_input,
  output logic                    configuration_enable,
  output logic                    busy,
  output logic                    done
);

  localparam int NUM_WORDS = calc_num_words(CFG_LEN, WORD_W);
  localparam int LAST_BITS = calc_last_bits(CFG_LEN, WORD_W);
  localparam int WCNT_W    = $clog2(NUM_WORDS + 1);
  localparam int BCNT_W    = $clog2(CFG_LEN + 1);
  localparam int REM_W     = $clog2(WORD_W + 1);

  localparam logic [WCNT_W-1:0] NUM_WORDS_C = WCNT_W'(NUM_WORDS);
  localparam logic [WCNT_W-1:0] LAST_IDX_C  = WCNT_W'(NUM_WORDS - 1);
  localparam logic [BCNT_W-1:0] CFG_LEN_C   = BCNT_W'(CFG_LEN);

  cfg_state_t        state;
  logic [WCNT_W-1:0] words_acc;
  logic [BCNT_W-1:0] bit_cnt;
  logic              hold_valid;
  logic              sr_valid;
  logic              sr_bit;
  logic              wr_en;
  logic [REM_W-1:0]  wr_bits;

  assign cfg.cfg_ready = (state == LOAD) && !hold_valid && (words_acc < NUM_WORDS_C);
  assign wr_en         = cfg.cfg_valid && cfg.cfg_ready;
  // The final word only carries the bits that remain in the frame.
  assign wr_bits       = (words_acc == LAST_IDX_C) ? REM_W'(LAST_BITS) : REM_W'(WORD_W);

  cfg_word_buffer #(
    .WORD_W (WORD_W)
  ) u_buf (
    .clk        (clk),
    .rst        (RST),
    .wr_en      (wr_en),
    .wr_word    (cfg.cfg_word),
    .wr_bits    (wr_bits),
    .shift_en   (sr_valid),
    .hold_valid (hold_valid),
    .sr_valid   (sr_valid),
    .sr_bit     (sr_bit)
  );

  // Frame sequencing, word/bit counters, busy and done.
  always_ff @(posedge clk) begin
    if (RST) begin
      state     <= IDLE;
      words_acc <= '0;
      bit_cnt   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg.cfg_start) begin
            state     <= LOAD;
            busy      <= 1'b1;
            words_acc <= '0;
            bit_cnt   <= '0;
          end
        end
        LOAD: begin
          if (wr_en) begin
            words_acc <= words_acc + 1'b1;
          end
          if (sr_valid) begin
            bit_cnt <= bit_cnt + 1'b1;
          end
          if (bit_cnt == CFG_LEN_C) begin
            state <= FIN;
            done  <= 1'b1;
          end
        end
        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Registered serial pins: one bit per cycle while the shift register holds data.
  always_ff @(posedge clk) begin
    if (RST) begin
      configuration_enable <= 1'b0;
      configuration_input  <= 1'b0;
    end else begin
      configuration_enable <= sr_valid;
      configuration_input  <= sr_valid & sr_bit;
    end
  end

endmodule

// File: tb/tb_dsp_config_serializer.sv
// Self-checking bench for dsp_config_serializer: three instances (40/16, 16/16, 1/16).
module tb_dsp_config_serializer;

  localparam int WW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          RST;
  logic [2:0]    st;
  logic [2:0]    vl;
  logic [WW-1:0] wd [3];
  logic [WW-1:0] fw [8];

  int total = 0;
  int bad   = 0;

  dsp_config_serializer_if #(.WORD_W(WW)) if0 ();
  dsp_config_serializer_if #(.WORD_W(WW)) if1 ();
  dsp_config_serializer_if #(.WORD_W(WW)) if2 ();

  assign if0.cfg_start = st[0];
  assign if1.cfg_start = st[1];
  assign if2.cfg_start = st[2];
  assign if0.cfg_valid = vl[0];
  assign if1.cfg_valid = vl[1];
  assign if2.cfg_valid = vl[2];
  assign if0.cfg_word  = wd[0];
  assign if1.cfg_word  = wd[1];
  assign if2.cfg_word  = wd[2];

  logic ci0, ci1, ci2, ce0, ce1, ce2, bz0, bz1, bz2, dn0, dn1, dn2;
  wire [2:0] ci_v = {ci2, ci1, ci0};
  wire [2:0] ce_v = {ce2, ce1, ce0};
  wire [2:0] bz_v = {bz2, bz1, bz0};
  wire [2:0] dn_v = {dn2, dn1, dn0};
  wire [2:0] rdy  = {if2.cfg_ready, if1.cfg_ready, if0.cfg_ready};

  dsp_config_serializer #(.CFG_LEN(40), .WORD_W(WW)) dut0 (
    .clk(clk), .RST(RST), .cfg(if0),
    .configuration_input(ci0), .configuration_enable(ce0), .busy(bz0), .done(dn0));
  dsp_config_serializer #(.CFG_LEN(16), .WORD_W(WW)) dut1 (
    .clk(clk), .RST(RST), .cfg(if1),
    .configuration_input(ci1), .configuration_enable(ce1), .busy(bz1), .done(dn1));
  dsp_config_serializer #(.CFG_LEN(1), .WORD_W(WW)) dut2 (
    .clk(clk), .RST(RST), .cfg(if2),
    .configuration_input(ci2), .configuration_enable(ce2), .busy(bz2), .done(dn2));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input int k, input string tag);
    check({tag, "_en"},    32'(ce_v[k]), 0);
    check({tag, "_in"},    32'(ci_v[k]), 0);
    check({tag, "_busy"},  32'(bz_v[k]), 0);
    check({tag, "_done"},  32'(dn_v[k]), 0);
    check({tag, "_ready"}, 32'(rdy[k]),  0);
  endtask

  // Drive one frame from fw[] on instance k and compare against the frame rules:
  // the serial stream is the first len bits of the word concatenation, LSB first.
  task automatic run_frame(input int k, input int len, input int offer,
                           input int stall_len, input bit stray, input int abort_after);
    int  nw;
    int  acc, got, ncyc, nen, ndone, first_acc, first_en, last_en, done_at, stall_cnt;
    bit  xfer, stalling, finished;
    logic [WW-1:0] w;
    nw = (len + WW - 1) / WW;
    acc = 0; got = 0; ncyc = 0; nen = 0; ndone = 0; stall_cnt = 0;
    first_acc = -1; first_en = -1; last_en = -1; done_at = -1; finished = 0;
    st[k] = 1'b1;
    vl[k] = 1'b0;
    step();
    st[k] = 1'b0;
    check("busy_after_start", 32'(bz_v[k]), 1);
    while (!finished && ncyc < 400) begin
      stalling = (acc == 2) && (stall_cnt < stall_len);
      vl[k] = (acc < offer) && !stalling;
      wd[k] = vl[k] ? fw[acc] : WW'($urandom);
      st[k] = stray && (ncyc == 12);
      if (acc >= nw) check("ready_after_last_word", 32'(rdy[k]), 0);
      xfer = vl[k] && rdy[k];
      if (stalling && rdy[k]) stall_cnt++;
      step();
      ncyc++;
      if (xfer) begin
        if (acc == 0) first_acc = ncyc;
        acc++;
      end
      if (ce_v[k]) begin
        if (got < len) begin
          w = fw[got / WW];
          check("serial_bit", 32'(ci_v[k]), 32'(w[got % WW]));
        end
        if (first_en < 0) first_en = ncyc;
        last_en = ncyc;
        nen++;
        got++;
      end else begin
        check("input_low_when_disabled", 32'(ci_v[k]), 0);
      end
      if (dn_v[k]) begin
        ndone++;
        done_at = ncyc;
      end else if (ndone > 0) begin
        finished = 1;
      end
      if (abort_after >= 0 && got == abort_after) break;
    end
    st[k] = 1'b0;
    vl[k] = 1'b0;
    if (abort_after >= 0) begin
      check("bits_before_abort", got, abort_after);
      RST = 1'b1;
      step();
      check_idle(k, "abort");
      RST = 1'b0;
      for (int i = 0; i < 6; i++) begin
        step();
        check("abort_no_done", 32'(dn_v[k]), 0);
        check("abort_no_enable", 32'(ce_v[k]), 0);
      end
      return;
    end
    check("frame_completed", 32'(finished), 1);
    check("enable_cycles", nen, len);
    check("done_pulses", ndone, 1);
    check("done_after_last_enable", done_at, last_en + 1);
    check("words_accepted", acc, nw);
    check("first_enable_latency", first_en - first_acc, 2);
    if (stall_len == 0) check("enable_contiguous", last_en - first_en + 1, len);
    if (stall_len >= 20) check("underrun_gap", 32'(last_en - first_en + 1 > len), 1);
    check("busy_fell_with_done", 32'(bz_v[k]), 0);
    check("ready_low_after_frame", 32'(rdy[k]), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("idle_no_enable", 32'(ce_v[k]), 0);
      check("idle_no_done", 32'(dn_v[k]), 0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1;
    st  = '1;
    vl  = '1;
    for (int k = 0; k < 3; k++) wd[k] = WW'($urandom);
    for (int i = 0; i < 8; i++) fw[i] = '0;

    // Reset held three cycles with start and valid asserted.
    for (int c = 0; c < 3; c++) begin
      step();
      for (int k = 0; k < 3; k++) check_idle(k, "reset");
    end
    st = '0;
    vl = '0;
    step();
    RST = 1'b0;
    step();
    for (int k = 0; k < 3; k++) check_idle(k, "post_reset");

    // Directed back-to-back frame; upper byte of 0x1234 falls outside the frame.
    fw[0] = 16'h00A5; fw[1] = 16'hFFFF; fw[2] = 16'h1234; fw[3] = 16'hBEEF;
    run_frame(0, 40, 3, 0, 1'b0, -1);

    // Producer stalls longer than one word's worth of slack before word 2.
    run_frame(0, 40, 3, 24, 1'b0, -1);

    // Stray start mid-frame and a fourth word on offer.
    for (int i = 0; i < 4; i++) fw[i] = WW'($urandom);
    run_frame(0, 40, 4, 0, 1'b1, -1);

    // Reset after 20 bits, then a complete fresh frame.
    for (int i = 0; i < 4; i++) fw[i] = WW'($urandom);
    run_frame(0, 40, 3, 0, 1'b0, 20);
    for (int i = 0; i < 4; i++) fw[i] = WW'($urandom);
    run_frame(0, 40, 3, 0, 1'b0, -1);

    // Random frames with and without an underrun.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 4; i++) fw[i] = WW'($urandom);
      run_frame(0, 40, 3 + int'($urandom_range(0, 1)), (r % 2 == 1) ? 24 : 0, 1'b0, -1);
    end

    // Exact single-word fit and a one-bit frame; extra words offered.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) fw[i] = WW'($urandom);
      run_frame(1, 16, 2, 0, 1'b0, -1);
      for (int i = 0; i < 4; i++) fw[i] = WW'($urandom);
      run_frame(2, 1, 2, 0, 1'b0, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
